// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
//   Sequential restoring divider: 2N-bit dividend / N-bit divisor gives a 2N-bit
//   quotient and an N-bit remainder, one quotient bit per clock, MSB first.
//   This is the inverse of the combinational array multiplier.
//
//   Optional feature macro: SEQ_DIVIDER_OVF_EN
//     When defined, adds output ovf: set when the quotient does not fit in
//     N bits, or on divide-by-zero.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   dividend   2N-bit numerator, sampled with start
//   divisor    N-bit denominator, sampled with start
//   busy       high whenever the unit is not IDLE
//   done       one-cycle completion pulse
//   quotient   2N-bit result, held until the next completion
//   remainder  N-bit result, held until the next completion
//   dbz        divide-by-zero flag for the last operation
//   ovf        (SEQ_DIVIDER_OVF_EN only) quotient overflow of N bits
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   quotient,
  output logic [N-1:0]     remainder,
`ifdef SEQ_DIVIDER_OVF_EN
  output logic             dbz,
  output logic             ovf
`else
  output logic             dbz
`endif
);

  localparam int CW = (2 * N > 1) ? $clog2(2 * N) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(2 * N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  // dvd shifts left each iteration: dividend bits leave at the top while
  // quotient bits enter at the bottom, so after 2N steps it holds the quotient.
  logic [2*N-1:0]   dvd;
  logic [N-1:0]     dvs;
  logic [N:0]       rem_acc;
  logic [CW-1:0]    count;

  logic [N:0]       r_shift;
  logic [N:0]       r_next;
  logic             q_bit;
  logic [2*N-1:0]   q_next;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    r_shift = {rem_acc[N-1:0], dvd[2*N-1]};
    r_next  = r_shift;
    q_bit   = 1'b0;
    if (r_shift >= {1'b0, dvs}) begin
      r_next = r_shift - {1'b0, dvs};
      q_bit  = 1'b1;
    end
    q_next = {dvd[2*N-2:0], q_bit};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the working registers are plain flops, not a memory array, so
      // clearing them on reset is cheap and keeps the unit fully deterministic.
      state     <= IDLE;
      dvd       <= '0;
      dvs       <= '0;
      rem_acc   <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
`ifdef SEQ_DIVIDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              // Divide-by-zero skips RUN and completes on the start edge.
              state     <= DONE;
              done      <= 1'b1;
              quotient  <= '1;
              remainder <= dividend[N-1:0];
              dbz       <= 1'b1;
`ifdef SEQ_DIVIDER_OVF_EN
              ovf       <= 1'b1;
`endif
            end else begin
              state   <= RUN;
              dvd     <= dividend;
              dvs     <= divisor;
              rem_acc <= '0;
              count   <= '0;
            end
          end
        end

        RUN: begin
          dvd     <= q_next;
          rem_acc <= r_next;
          count   <= count + 1'b1;
          if (count == LAST_COUNT) begin
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next[N-1:0];
            dbz       <= 1'b0;
`ifdef SEQ_DIVIDER_OVF_EN
            ovf       <= |q_next[2*N-1:N];
`endif
          end
        end

        DONE: begin
          // start is deliberately not sampled here.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider (N=4). A transaction-level model computes
//   results with / and %, and predicts completion timing from the latency
//   rules; a compare process checks every DUT output on every falling edge.
//   Directed cases pin the model with hand-computed values; a randomized phase
//   exercises start pulses, busy-time starts and divide-by-zero.
// -----------------------------------------------------------------------------
module tb_seq_divider;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [2*N-1:0]   dividend = '0;
  logic [N-1:0]     divisor = '0;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   quotient;
  logic [N-1:0]     remainder;
  logic             dbz;
`ifdef SEQ_DIVIDER_OVF_EN
  logic             ovf;
`endif

  seq_divider #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
`ifdef SEQ_DIVIDER_OVF_EN
    .dbz       (dbz),
    .ovf       (ovf)
`else
    .dbz       (dbz)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one request at a time; a result becomes visible a fixed
  // number of edges after acceptance, then the unit is idle one edge later.
  // ---------------------------------------------------------------------------
  bit             m_busy = 0;
  bit             m_done = 0;
  bit             m_dbz  = 0;
  bit             m_ovf  = 0;
  int             m_left = 0;
  logic [2*N-1:0] m_q = '0;
  logic [N-1:0]   m_r = '0;
  logic [2*N-1:0] p_q = '0;
  logic [N-1:0]   p_r = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_dbz = 0; m_ovf = 0; m_left = 0;
      m_q = '0; m_r = '0;
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_q    = p_q;
        m_r    = p_r;
        m_dbz  = 0;
        m_ovf  = (p_q >> N) != 0;
        m_done = 1;
      end
    end else if (start) begin
      m_busy = 1;
      if (divisor == 0) begin
        m_q    = '1;
        m_r    = dividend[N-1:0];
        m_dbz  = 1;
        m_ovf  = 1;
        m_done = 1;
      end else begin
        p_q    = dividend / {{N{1'b0}}, divisor};
        p_r    = N'(dividend % {{N{1'b0}}, divisor});
        m_left = 2 * N;
      end
    end
  end

  // Compare process plus event counters used by directed checks.
  int done_cnt = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(m_done));
    check("quotient", 64'(quotient), 64'(m_q));
    check("remainder", 64'(remainder), 64'(m_r));
    check("dbz", 64'(dbz), 64'(m_dbz));
`ifdef SEQ_DIVIDER_OVF_EN
    check("ovf", 64'(ovf), 64'(m_ovf));
`endif
  end

  // Issue one request and wait for done; lat counts falling edges from the
  // start edge to the first one showing done (normal op: 2N+1, dbz: 1).
  task automatic do_op(input logic [2*N-1:0] a, input logic [N-1:0] b, output int lat);
    bit got;
    @(negedge clk); #1;
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    lat = 1; got = done;
    #1 start = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      got = done;
    end
    if (!got) check("done_timeout", 64'(0), 64'(1));
  endtask

  int lat;
  int d0, b0;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_quotient", 64'(quotient), 64'(0));
    check("reset_dbz", 64'(dbz), 64'(0));
    #1 rst_n = 1'b1;

    // Basic divisions
    do_op(8'd143, 4'd11, lat);
    check("143/11 q", 64'(quotient), 64'(13));
    check("143/11 r", 64'(remainder), 64'(0));
    check("143/11 lat", 64'(lat), 64'(9));
    do_op(8'd200, 4'd7, lat);
    check("200/7 q", 64'(quotient), 64'(28));
    check("200/7 r", 64'(remainder), 64'(4));
    check("200/7 dbz", 64'(dbz), 64'(0));
`ifdef SEQ_DIVIDER_OVF_EN
    check("200/7 ovf", 64'(ovf), 64'(1));
`endif
    do_op(8'd225, 4'd15, lat);
    check("225/15 q", 64'(quotient), 64'(15));
    check("225/15 r", 64'(remainder), 64'(0));
    do_op(8'd255, 4'd1, lat);
    check("255/1 q", 64'(quotient), 64'(255));

    // Divide by zero, then a normal op clears dbz
    do_op(8'd100, 4'd0, lat);
    check("100/0 q", 64'(quotient), 64'(255));
    check("100/0 r", 64'(remainder), 64'(4));
    check("100/0 dbz", 64'(dbz), 64'(1));
    check("100/0 lat", 64'(lat), 64'(1));
`ifdef SEQ_DIVIDER_OVF_EN
    check("100/0 ovf", 64'(ovf), 64'(1));
`endif
    do_op(8'd143, 4'd11, lat);
    check("after dbz", 64'(dbz), 64'(0));

    // Start while busy: second request must be ignored
    repeat (2) @(negedge clk);
    d0 = done_cnt; b0 = busy_cnt;
    #1 start = 1'b1; dividend = 8'd143; divisor = 4'd11;
    @(negedge clk); #1 start = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    start = 1'b1; dividend = 8'd50; divisor = 4'd5;
    @(negedge clk); #1 start = 1'b0;
    repeat (14) @(negedge clk);
    check("busy_start done pulses", 64'(done_cnt - d0), 64'(1));
    check("busy_start busy cycles", 64'(busy_cnt - b0), 64'(9));
    check("busy_start q", 64'(quotient), 64'(13));
    check("busy_start r", 64'(remainder), 64'(0));

    // Reset in the middle of 200/7
    d0 = done_cnt;
    @(negedge clk); #1;
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(negedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_reset busy", 64'(busy), 64'(0));
    check("mid_reset q", 64'(quotient), 64'(0));
    check("mid_reset r", 64'(remainder), 64'(0));
    #1 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("mid_reset no done", 64'(done_cnt - d0), 64'(0));
    do_op(8'd0, 4'd5, lat);
    check("0/5 q", 64'(quotient), 64'(0));
    check("0/5 r", 64'(remainder), 64'(0));
    check("0/5 lat", 64'(lat), 64'(9));

    // Exhaustive inverse of the multiplier
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_op(8'(a * b), 4'(b), lat);
        check("inverse q", 64'(quotient), 64'(a));
        check("inverse r", 64'(remainder), 64'(0));
`ifdef SEQ_DIVIDER_OVF_EN
        check("inverse ovf", 64'(ovf), 64'(0));
`endif
      end
    end

    // Randomized traffic: random start pulses and operands every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      start    = ($urandom % 3) == 0;
      dividend = 8'($urandom);
      divisor  = (($urandom % 6) == 0) ? 4'd0 : 4'($urandom);
    end
    @(negedge clk); #1 start = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
